register_file_mp: RTL

- Parametrised successor to the team's 32x32 two-read/one-write register file.
- Generalised: data width, depth (via selector width) and number of read ports.
- Added: byte-enable writes, write-to-read bypass, hardwired zero register, per-register busy scoreboard and a sequenced clear engine.
- Sits in the CPU decode/writeback stage, between the instruction decoder, hazard unit and writeback mux.

---
 rtl/register_file_mp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
`timescale 1ns/1ps
// register_file_mp: parametrised multi-read-port register file with byte-enable writes,
//   write-to-read bypass, hardwired zero register, busy scoreboard and sequenced clear.
// Latency: writes, reserves and clear sweeps commit on the rising edge; reads are combinational.
// Backpressure: none; while a clear sweep runs (Clear_Busy_o=1), writes, reserves and
//   clear requests are dropped rather than stalled. Upstream must hold off.
// Ports: clk, rst (async active-low); Reg_Write_i/Write_Register_i/Write_Data_i/Write_Byte_En_i
//   form the write port; Read_Register_i drives per-port Read_Data_o and Busy_o;
//   Reserve_i/Reserve_Register_i mark a pending producer; Clear_i starts the sweep
//   and Clear_Busy_o flags it.
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int SELECTOR = 5,
    parameter int N_READ   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Reg_Write_i,
    input  logic [SELECTOR-1:0]          Write_Register_i,
    input  logic [WIDTH-1:0]             Write_Data_i,
    input  logic [WIDTH/8-1:0]           Write_Byte_En_i,
    input  logic [N_READ*SELECTOR-1:0]   Read_Register_i,
    output logic [N_READ*WIDTH-1:0]      Read_Data_o,
    output logic [N_READ-1:0]            Busy_o,
    input  logic                         Reserve_i,
    input  logic [SELECTOR-1:0]          Reserve_Register_i,
    input  logic                         Clear_i,
    output logic                         Clear_Busy_o
);
    localparam int DEPTH  = 1 << SELECTOR;
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t              state, state_nxt;
    logic [SELECTOR-1:0] sweep_cnt, sweep_cnt_nxt;
    logic [WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic                idle;
    logic                wr_commit;
    logic                rsv_commit;

    assign idle         = (state == IDLE);
    assign Clear_Busy_o = (state == CLEARING);

    // Writes and reserves only take effect outside the sweep; register 0 never
    // stores data or becomes busy when it is hardwired.
    assign wr_commit  = Reg_Write_i && idle &&
                        !((ZERO_REG != 0) && (Write_Register_i == '0));
    assign rsv_commit = Reserve_i && idle &&
                        !((ZERO_REG != 0) && (Reserve_Register_i == '0));

    // Clear engine: next-state and sweep counter.
    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        case (state)
            IDLE: begin
                if (Clear_i) begin
                    state_nxt     = CLEARING;
                    sweep_cnt_nxt = '0;
                end
            end
            CLEARING: begin
                sweep_cnt_nxt = sweep_cnt + 1'b1;
                // Last entry is cleared on this edge; counter wraps to 0 on its own.
                if (sweep_cnt == {SELECTOR{1'b1}}) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    // Storage array: sweep clear takes precedence, otherwise byte-masked write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEARING) begin
            regs[sweep_cnt] <= '0;
        end else if (wr_commit) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (Write_Byte_En_i[b]) begin
                    regs[Write_Register_i][8*b +: 8] <= Write_Data_i[8*b +: 8];
                end
            end
        end
    end

    // Scoreboard: the reserve is applied after the write-clear so a register
    // reserved and written in the same cycle stays busy for the new producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else if (state == CLEARING) begin
            busy[sweep_cnt] <= 1'b0;
        end else begin
            if (wr_commit) begin
                busy[Write_Register_i] <= 1'b0;
            end
            if (rsv_commit) begin
                busy[Reserve_Register_i] <= 1'b1;
            end
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < N_READ; k++) begin : g_read
        logic [SELECTOR-1:0] addr;
        logic [WIDTH-1:0]    rd_val;
        logic                bsy_val;

        assign addr = Read_Register_i[k*SELECTOR +: SELECTOR];

        always_comb begin
            rd_val  = regs[addr];
            bsy_val = busy[addr];
            if ((BYPASS != 0) && idle && Reg_Write_i && (addr == Write_Register_i)) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (Write_Byte_En_i[b]) begin
                        rd_val[8*b +: 8] = Write_Data_i[8*b +: 8];
                    end
                end
            end
            // A landing write retires the producer unless a new one reserves it now.
            if ((BYPASS != 0) && wr_commit && (addr == Write_Register_i) &&
                !(rsv_commit && (Reserve_Register_i == addr))) begin
                bsy_val = 1'b0;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_val  = '0;
                bsy_val = 1'b0;
            end
        end

        assign Read_Data_o[k*WIDTH +: WIDTH] = rd_val;
        assign Busy_o[k]                     = bsy_val;
    end

endmodule
